// File: rtl/mac_acc16_if.sv
`default_nettype none
// ============================================================================
// Module   : mac_acc16_if
// Brief    : Product-stream and result handshake bundle for mac_acc16.
// Revision : 1.0 - initial release
// ============================================================================
interface mac_acc16_if #(
    parameter int ACC_W = 24
) ();
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      mul;
    logic             res_valid;
    logic             res_ready;
    logic [ACC_W-1:0] res;

    // slave: the accumulator; master: whoever feeds products and takes results
    modport slave (
        input  in_valid,
        input  mul,
        input  res_ready,
        output in_ready,
        output res_valid,
        output res
    );

    modport master (
        output in_valid,
        output mul,
        output res_ready,
        input  in_ready,
        input  res_valid,
        input  res
    );
endinterface
`default_nettype wire

// File: rtl/mac_acc16.sv
`default_nettype none
// ============================================================================
// Module   : mac_acc16
// Brief    : Sums a programmed number of 16-bit products into an ACC_W-bit
//            accumulator with sticky overflow. Define MAC_ACC16_SATURATE_EN to
//            saturate instead of wrapping on overflow.
// Revision : 1.0 - initial release
// ============================================================================
module mac_acc16 #(
    parameter int ACC_W = 24,
    parameter int CNT_W = 8
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             start,
    input  wire logic [CNT_W-1:0] len,
    mac_acc16_if.slave            bus,
    output logic                  ovf,
    output logic                  busy
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    state_t           r_state;
    logic [CNT_W-1:0] r_len;
    logic [CNT_W-1:0] r_cnt;
    logic [ACC_W-1:0] r_acc;
    logic             r_ovf;

    logic [ACC_W:0]   w_sum;
    logic [ACC_W-1:0] w_acc_next;
    logic             w_last;

    // One extra bit on the add exposes the carry that drives ovf
    assign w_sum  = {1'b0, r_acc} + {{(ACC_W+1-16){1'b0}}, bus.mul};
    assign w_last = (r_cnt == (r_len - c_cnt_one));

    always_comb begin
        w_acc_next = w_sum[ACC_W-1:0];
`ifdef MAC_ACC16_SATURATE_EN
        if (w_sum[ACC_W]) begin
            w_acc_next = '1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_len   <= '0;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_len   <= len;
                        r_cnt   <= '0;
                        r_acc   <= '0;
                        r_ovf   <= 1'b0;
                        r_state <= (len == '0) ? S_DONE : S_ACC;
                    end
                end
                S_ACC: begin
                    // in_ready is 1 throughout ACC, so in_valid alone is the handshake
                    if (bus.in_valid) begin
                        r_acc <= w_acc_next;
                        r_cnt <= r_cnt + c_cnt_one;
                        if (w_sum[ACC_W]) begin
                            r_ovf <= 1'b1;
                        end
                        if (w_last) begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (bus.res_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == S_ACC);
    assign bus.res_valid = (r_state == S_DONE);
    assign bus.res       = r_acc;
    assign busy          = (r_state != S_IDLE);
    assign ovf           = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_mac_acc16.sv
`default_nettype none
// ============================================================================
// Module   : tb_mac_acc16
// Brief    : Scoreboard bench driving a 24-bit and a 17-bit mac_acc16 in lockstep.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mac_acc16;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  len;
    logic        in_valid;
    logic [15:0] mul;
    logic        res_ready;
    logic        ovf24, busy24, ovf17, busy17;

    always #5 clk = ~clk;

    mac_acc16_if #(.ACC_W(24)) if24 ();
    mac_acc16_if #(.ACC_W(17)) if17 ();

    assign if24.in_valid  = in_valid;
    assign if24.mul       = mul;
    assign if24.res_ready = res_ready;
    assign if17.in_valid  = in_valid;
    assign if17.mul       = mul;
    assign if17.res_ready = res_ready;

    mac_acc16 #(.ACC_W(24), .CNT_W(8)) dut24 (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .bus(if24.slave), .ovf(ovf24), .busy(busy24)
    );

    mac_acc16 #(.ACC_W(17), .CNT_W(8)) dut17 (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .bus(if17.slave), .ovf(ovf17), .busy(busy17)
    );

    typedef struct {
        longint res;
        bit     ovf;
    } exp_t;

    exp_t   q24[$];
    exp_t   q17[$];
    int     prods[$];
    int     n_checks = 0;
    int     n_errs   = 0;
    longint cyc      = 0;
    longint t_start  = 0;

    always @(posedge clk) cyc++;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference accumulation over the products queue for a given width
    function automatic void model(input int w, output longint r, output bit o);
        longint acc = 0;
        longint lim = longint'(1) << w;
        o = 1'b0;
        foreach (prods[i]) begin
            longint s = acc + longint'(prods[i]);
            if (s >= lim) begin
                o = 1'b1;
`ifdef MAC_ACC16_SATURATE_EN
                acc = lim - 1;
`else
                acc = s - lim;
`endif
            end else begin
                acc = s;
            end
        end
        r = acc;
    endfunction

    task automatic do_start(input int n);
        start   = 1'b1;
        len     = 8'(n);
        t_start = cyc;
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic send(input int p);
        int t = 0;
        while (!if24.in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!if24.in_ready) check_eq("in_ready_timeout", 0, 1);
        in_valid = 1'b1;
        mul      = 16'(p);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic run_job(input int stall_idx, input int stall_n, input int hold, input bit poke);
        longint r;
        bit     o;
        exp_t   e24, e17;
        int     t = 0;
        int     n = prods.size();
        model(24, r, o); e24.res = r; e24.ovf = o; q24.push_back(e24);
        model(17, r, o); e17.res = r; e17.ovf = o; q17.push_back(e17);
        do_start(n);
        foreach (prods[i]) begin
            if (i == stall_idx) repeat (stall_n) @(negedge clk);
            if (poke && i == 1) begin
                start = 1'b1;
                len   = 8'd9;
            end
            send(prods[i]);
            start = 1'b0;
        end
        while (!if24.res_valid && t < 400) begin
            @(negedge clk);
            t++;
        end
        check_eq("res_valid", longint'(if24.res_valid), 1);
        if (stall_n == 0) check_eq("latency", cyc - t_start, longint'(n + 1));
        e24 = q24.pop_front();
        e17 = q17.pop_front();
        check_eq("res24", longint'(if24.res), e24.res);
        check_eq("ovf24", longint'(ovf24), longint'(e24.ovf));
        check_eq("res17", longint'(if17.res), e17.res);
        check_eq("ovf17", longint'(ovf17), longint'(e17.ovf));
        check_eq("done_in_ready", longint'(if24.in_ready | if17.in_ready), 0);
        repeat (hold) begin
            @(negedge clk);
            check_eq("hold_res", longint'(if24.res), e24.res);
            check_eq("hold_valid", longint'(if24.res_valid), 1);
            check_eq("hold_in_ready", longint'(if24.in_ready), 0);
        end
        res_ready = 1'b1;
        if (poke) begin
            start = 1'b1;
            len   = 8'd9;
        end
        @(negedge clk);
        res_ready = 1'b0;
        start     = 1'b0;
        check_eq("idle_valid", longint'(if24.res_valid | if17.res_valid), 0);
        check_eq("idle_busy", longint'(busy24 | busy17), 0);
        check_eq("idle_res", longint'(if24.res), e24.res);
        if (poke) begin
            @(negedge clk);
            check_eq("post_busy", longint'(busy24 | busy17), 0);
            check_eq("post_in_ready", longint'(if24.in_ready), 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; mul = '0; res_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_eq("rst_in_ready", longint'(if24.in_ready | if17.in_ready), 0);
        check_eq("rst_res_valid", longint'(if24.res_valid | if17.res_valid), 0);
        check_eq("rst_res", longint'(if24.res), 0);
        check_eq("rst_ovf", longint'(ovf24 | ovf17), 0);
        check_eq("rst_busy", longint'(busy24 | busy17), 0);

        // Reset abandons a partially-accumulated job
        do_start(3);
        send(100);
        send(200);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("mid_rst_busy", longint'(busy24 | busy17), 0);
        check_eq("mid_rst_in_ready", longint'(if24.in_ready), 0);
        check_eq("mid_rst_res", longint'(if24.res), 0);
        check_eq("mid_rst_ovf", longint'(ovf24), 0);
        prods = '{5};
        run_job(-1, 0, 0, 1'b0);

        prods = '{65025, 10, 0, 1};
        run_job(2, 2, 5, 1'b0);

        prods = {};
        run_job(-1, 0, 1, 1'b0);

        prods = '{65025, 65025, 65025};
        run_job(-1, 0, 0, 1'b0);
        prods = '{7};
        run_job(-1, 0, 0, 1'b0);

        prods = '{11, 22};
        run_job(-1, 0, 0, 1'b1);

        prods = {};
        for (int i = 0; i < 255; i++) prods.push_back(65025);
        run_job(-1, 0, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/mac_acc16.md
Name: mac_acc16

Overview:
- Downstream accumulation stage for the 8x8 unsigned array multiplier.
- Consumes the multiplier's 16-bit product stream through a valid/ready handshake and sums a programmed number of products into a wide accumulator.
- Presents the final sum on a result handshake and flags overflow.
- Used for dot-product and FIR-tap sums in the lab datapath.

Parameters:
- ACC_W, 24, accumulator/result width in bits; must be >= 16.
- CNT_W, 8, width of the length field and the internal product counter.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a job; honoured only in IDLE.
- len  input  CNT_W  number of products to accumulate; sampled on an accepted start.
- in_valid  input  1  a product is present on mul.
- in_ready  output  1  block accepts a product this cycle.
- mul  input  16  unsigned product from the multiplier.
- res_valid  output  1  res holds the final sum.
- res_ready  input  1  consumer accepts res.
- res  output  ACC_W  accumulated sum.
- ovf  output  1  sticky overflow flag for the current or last job.
- busy  output  1  block is not in IDLE.

Behaviour:
- Reset (rst high at a clk edge):
  - Every register is cleared and the FSM goes to IDLE.
  - Outputs: in_ready=0, res_valid=0, res=0, ovf=0, busy=0.
  - A reset in the middle of a job abandons it; no partial result is ever presented.
- FSM states: IDLE, ACC, DONE. All outputs are registered or decoded from state only; there is no combinational path from in_valid or res_ready to any output.
- IDLE:
  - in_ready=0, res_valid=0, busy=0.
  - On start=1: latch len, clear the accumulator, clear the counter and clear ovf.
  - If len!=0, go to ACC. If len==0, go to DONE with res=0.
- ACC:
  - in_ready=1, busy=1.
  - Each cycle with in_valid && in_ready: acc <= acc + zero-extended mul, and cnt <= cnt+1.
  - On the handshake where cnt == len_latched-1, go to DONE. The final sum is visible on res in the DONE cycle, one clk after the last accepted product.
  - Cycles with in_valid=0 are stalls; the accumulator and counter hold.
- DONE:
  - in_ready=0, res_valid=1, busy=1, and res is held stable.
  - On res_ready=1, go to IDLE; res_valid drops on the next cycle.
  - res keeps its value in IDLE until the next accepted start.
- start is ignored in ACC and DONE. A start that arrives in the same cycle as the DONE->IDLE handshake is also ignored; it must be re-issued in IDLE.
- Arithmetic:
  - The add is unsigned, ACC_W+1 bits wide internally.
  - If the carry-out bit is 1, set ovf. ovf stays set until the next accepted start or reset.
  - Without the optional feature, the accumulator wraps modulo 2^ACC_W.
- Throughput and latency:
  - One product per cycle while in ACC.
  - A job of N products with no stalls takes 1 cycle (start) + N cycles (ACC) before res_valid.
- The largest len value, 2^CNT_W-1, is legal. The counter must not wrap before the terminal compare.
- rst has priority over every other input in every state.

Optional Feature:
- Macro: MAC_ACC16_SATURATE_EN.
- When defined:
  - On an overflowing add, the accumulator is set to 2^ACC_W-1 and stays there for the rest of the job. Later adds keep it saturated.
  - ovf is set as normal.
- When undefined: the accumulator wraps modulo 2^ACC_W and ovf is set as normal.
- No ports change in either case.

Test Plan:
- Reset mid-job:
  - ACC_W=24. Issue start with len=3, accept mul=100 and mul=200, then assert rst for 1 cycle.
  - Required: busy=0, in_ready=0, res=0, ovf=0 on the next cycle.
  - Then start with len=1 and send mul=5. Required: res=5.
- Basic job with stalls and backpressure:
  - start with len=4. Send products 255*255=65025, 10, 0, 1, with in_valid low for 2 cycles between the 2nd and 3rd products.
  - Required: res_valid=1, res=65036, ovf=0.
  - Hold res_ready=0 for 5 cycles. Required: res and res_valid stay stable, in_ready=0.
- Empty job:
  - start with len=0.
  - Required: the next cycle is in DONE with res_valid=1, res=0, and in_ready stays 0 throughout.
- Overflow with ACC_W=17:
  - start with len=3 and send 65025 three times.
  - Without the macro: res=64003, ovf=1.
  - With MAC_ACC16_SATURATE_EN: res=131071, ovf=1.
  - A following start with len=1 and mul=7 must give res=7, ovf=0.
- Ignored start:
  - Pulse start with len=9 while in ACC of a len=2 job, and again in the DONE->IDLE handshake cycle.
  - Required: the job finishes after exactly 2 products, and the block returns to IDLE with busy=0.
- Full length, no stalls:
  - ACC_W=24, len=255, mul=65025 every cycle.
  - Required: res_valid rises exactly 256 cycles after start, res=16581375, ovf=0.
